me_frame_loader: RTL and testbench

//  Memory-side responder and frame writer for the motion-estimator top_level.
//  - Loads a 16x16 reference block, then a 32x32 search window, from a valid/ready pixel stream.
//  - Serves the estimator's three read ports: address_ref, address_search1 and address_search2.
//  - Drives start_signal, waits for process_completed, and returns best_distance/motion vectors

---
 rtl/me_frame_loader.sv | 166 ++++++++++++++++
 tb/tb_me_frame_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_loader.sv
// Pixel-stream frame loader and result collector for the motion estimator.
// It loads the reference and search memories, runs the estimator, and returns its result.
module me_frame_loader #(
   parameter int PIX_W          = 8,
   parameter int REF_DIM        = 16,
   parameter int SRCH_DIM       = 32,
   parameter int MV_W           = 4,
   parameter int TIMEOUT_CYCLES = 4200,
   parameter int REF_AW         = $clog2(REF_DIM*REF_DIM),
   parameter int SRCH_AW        = $clog2(SRCH_DIM*SRCH_DIM)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PIX_W-1:0]       pixel_data,
   input  logic                   pixel_valid,
   input  logic                   pixel_last,
   output logic                   pixel_ready,
   input  logic [REF_AW-1:0]      address_ref,
   input  logic [SRCH_AW-1:0]     address_search1,
   input  logic [SRCH_AW-1:0]     address_search2,
   output logic [PIX_W-1:0]       ref_data,
   output logic [PIX_W-1:0]       search_data1,
   output logic [PIX_W-1:0]       search_data2,
   output logic                   start_signal,
   input  logic                   process_completed,
   input  logic [7:0]             best_distance,
   input  logic [MV_W-1:0]        motion_vector_x,
   input  logic [MV_W-1:0]        motion_vector_y,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [7:0]             result_best_distance,
   output logic signed [MV_W-1:0] result_mv_x,
   output logic signed [MV_W-1:0] result_mv_y,
   output logic                   result_perfect,
   output logic                   result_miss,
   output logic                   frame_error,
   output logic                   timeout_error,
   output logic                   busy
);

   localparam int REF_N  = REF_DIM*REF_DIM;
   localparam int SRCH_N = SRCH_DIM*SRCH_DIM;
   localparam int RUN_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {LOAD_REF, LOAD_SRCH, RUN, RESULT} state_t;

   state_t              state;
   logic [SRCH_AW-1:0]  wr_cnt;
   logic [RUN_W-1:0]    run_cnt;
   logic [PIX_W-1:0]    ref_mem  [REF_N];
   logic [PIX_W-1:0]    srch_mem [SRCH_N];

   logic accept, ref_we, srch_we, ref_done, srch_done;

   always_comb begin
      accept    = pixel_valid & pixel_ready;
      ref_we    = accept & ~reset & (state == LOAD_REF);
      srch_we   = accept & ~reset & (state == LOAD_SRCH);
      ref_done  = (wr_cnt == SRCH_AW'(REF_N-1));
      srch_done = (wr_cnt == SRCH_AW'(SRCH_N-1));
      busy      = (state != LOAD_REF) || (wr_cnt != '0);
   end

   // Memory arrays carry no reset; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (ref_we)  ref_mem[wr_cnt[REF_AW-1:0]] <= pixel_data;
      if (srch_we) srch_mem[wr_cnt]            <= pixel_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ref_data     <= '0;
         search_data1 <= '0;
         search_data2 <= '0;
      end else begin
         ref_data     <= ref_mem[address_ref];
         search_data1 <= srch_mem[address_search1];
         search_data2 <= srch_mem[address_search2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= LOAD_REF;
         wr_cnt               <= '0;
         run_cnt              <= '0;
         pixel_ready          <= 1'b0;
         start_signal         <= 1'b0;
         result_valid         <= 1'b0;
         result_best_distance <= '0;
         result_mv_x          <= '0;
         result_mv_y          <= '0;
         result_perfect       <= 1'b0;
         result_miss          <= 1'b0;
         frame_error          <= 1'b0;
         timeout_error        <= 1'b0;
      end else begin
         frame_error   <= 1'b0;
         timeout_error <= 1'b0;
         case (state)
            LOAD_REF: begin
               pixel_ready <= 1'b1;
               if (accept) begin
                  if (pixel_last) begin
                     frame_error <= 1'b1;
                     wr_cnt      <= '0;
                  end else if (ref_done) begin
                     state  <= LOAD_SRCH;
                     wr_cnt <= '0;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            LOAD_SRCH: begin
               pixel_ready <= 1'b1;
               if (accept) begin
                  // pixel_last must coincide exactly with the final search pixel
                  if (pixel_last != srch_done) begin
                     frame_error <= 1'b1;
                     state       <= LOAD_REF;
                     wr_cnt      <= '0;
                  end else if (pixel_last) begin
                     state        <= RUN;
                     wr_cnt       <= '0;
                     run_cnt      <= '0;
                     pixel_ready  <= 1'b0;
                     start_signal <= 1'b1;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               pixel_ready <= 1'b0;
               run_cnt     <= run_cnt + 1'b1;
               if (process_completed) begin
                  result_best_distance <= best_distance;
                  result_mv_x          <= motion_vector_x;
                  result_mv_y          <= motion_vector_y;
                  result_perfect       <= (best_distance == 8'h00);
                  result_miss          <= (best_distance == 8'hFF);
                  result_valid         <= 1'b1;
                  start_signal         <= 1'b0;
                  state                <= RESULT;
               end else if (run_cnt == RUN_W'(TIMEOUT_CYCLES-1)) begin
                  timeout_error <= 1'b1;
                  start_signal  <= 1'b0;
                  pixel_ready   <= 1'b1;
                  state         <= LOAD_REF;
               end
            end
            RESULT: begin
               pixel_ready <= 1'b0;
               if (result_ready) begin
                  result_valid <= 1'b0;
                  pixel_ready  <= 1'b1;
                  state        <= LOAD_REF;
               end
            end
            default: state <= LOAD_REF;
         endcase
      end
   end

endmodule

// File: tb/tb_me_frame_loader.sv
// Directed self-checking bench for me_frame_loader: load, run, result, framing,
// timeout and reset scenarios with hand-computed expectations.
module tb_me_frame_loader;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        pixel_data;
   logic              pixel_valid, pixel_last, pixel_ready;
   logic [7:0]        address_ref;
   logic [9:0]        address_search1, address_search2;
   logic [7:0]        ref_data, search_data1, search_data2;
   logic              start_signal, process_completed;
   logic [7:0]        best_distance;
   logic [3:0]        motion_vector_x, motion_vector_y;
   logic              result_valid, result_ready;
   logic [7:0]        result_best_distance;
   logic signed [3:0] result_mv_x, result_mv_y;
   logic              result_perfect, result_miss, frame_error, timeout_error, busy;

   int errors = 0;
   int checks = 0;
   logic fe_seen;

   always #5 clk = ~clk;

   me_frame_loader #(.PIX_W(8), .REF_DIM(16), .SRCH_DIM(32), .MV_W(4), .TIMEOUT_CYCLES(4200)) dut (
      .clk(clk), .reset(reset),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_last(pixel_last), .pixel_ready(pixel_ready),
      .address_ref(address_ref), .address_search1(address_search1), .address_search2(address_search2),
      .ref_data(ref_data), .search_data1(search_data1), .search_data2(search_data2),
      .start_signal(start_signal), .process_completed(process_completed),
      .best_distance(best_distance), .motion_vector_x(motion_vector_x), .motion_vector_y(motion_vector_y),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_best_distance(result_best_distance), .result_mv_x(result_mv_x), .result_mv_y(result_mv_y),
      .result_perfect(result_perfect), .result_miss(result_miss),
      .frame_error(frame_error), .timeout_error(timeout_error), .busy(busy)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_px(input logic [7:0] d, input logic last);
      pixel_data  = d;
      pixel_last  = last;
      pixel_valid = 1'b1;
      tick();
      pixel_valid = 1'b0;
      pixel_last  = 1'b0;
      if (frame_error) fe_seen = 1'b1;
   endtask

   // Pixel k carries k%256, so search pixel j holds j%256 as well.
   task automatic send_frame(input int first, input int n, input int last_at);
      for (int k = first; k < first + n; k++) send_px(k[7:0], k == last_at);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got 0 expected 1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset = 1'b1; pixel_data = '0; pixel_valid = 1'b0; pixel_last = 1'b0;
      address_ref = '0; address_search1 = '0; address_search2 = '0;
      process_completed = 1'b0; best_distance = '0; motion_vector_x = '0; motion_vector_y = '0;
      result_ready = 1'b0; fe_seen = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_pixel_ready", pixel_ready, 0);
      check("rst_start", start_signal, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ref_data", ref_data, 0);
      tick();
      check("ready_after_reset", pixel_ready, 1);

      // 1: full frame and read ports
      send_frame(0, 1279, -1);
      check("t1_no_start_early", start_signal, 0);
      check("t1_busy", busy, 1);
      send_px(8'd255, 1'b1);
      check("t1_start", start_signal, 1);
      check("t1_ready_low", pixel_ready, 0);
      check("t1_no_frame_err", fe_seen, 0);
      address_search1 = 10'd300; address_search2 = 10'd1023; address_ref = 8'd77;
      tick();
      check("t1_search1", search_data1, 44);
      check("t1_search2", search_data2, 255);
      check("t1_ref", ref_data, 77);

      // 2: perfect result with sign conversion
      process_completed = 1'b1; best_distance = 8'h00; motion_vector_x = 4'd13; motion_vector_y = 4'd3;
      tick();
      process_completed = 1'b0;
      check("t2_valid", result_valid, 1);
      check("t2_mv_x", result_mv_x, -3);
      check("t2_mv_y", result_mv_y, 3);
      check("t2_perfect", result_perfect, 1);
      check("t2_miss", result_miss, 0);
      check("t2_start", start_signal, 0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("t2_valid_clr", result_valid, 0);
      check("t2_ready", pixel_ready, 1);
      check("t2_busy", busy, 0);

      // 3: misplaced pixel_last on pixel 500
      fe_seen = 1'b0;
      send_frame(0, 500, 499);
      check("t3_frame_err", frame_error, 1);
      check("t3_start", start_signal, 0);
      send_px(8'hA5, 1'b0);
      check("t3_pulse_1cyc", frame_error, 0);
      address_ref = 8'd0;
      tick();
      check("t3_ref0", ref_data, 165);

      // 4: timeout (frame continues from pixel 1)
      fe_seen = 1'b0;
      send_frame(1, 1279, 1279);
      check("t4_start", start_signal, 1);
      check("t4_no_frame_err", fe_seen, 0);
      n = 0;
      while (n < 5000) begin
         tick();
         n++;
         if (timeout_error) break;
      end
      check("t4_run_cycles", n, 4200);
      check("t4_start_clr", start_signal, 0);
      check("t4_ready", pixel_ready, 1);
      check("t4_no_result", result_valid, 0);
      tick();
      check("t4_pulse_1cyc", timeout_error, 0);
      check("t4_busy", busy, 0);

      // 5: miss result held under backpressure; late completion ignored
      send_frame(0, 1280, 1279);
      process_completed = 1'b1; best_distance = 8'hFF; motion_vector_x = 4'd8; motion_vector_y = 4'd9;
      tick();
      best_distance = 8'h11; motion_vector_x = 4'd1; motion_vector_y = 4'd1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_hold_dist", result_best_distance, 255);
         check("t5_hold_valid", result_valid, 1);
      end
      process_completed = 1'b0;
      check("t5_mv_x", result_mv_x, -8);
      check("t5_mv_y", result_mv_y, -7);
      check("t5_miss", result_miss, 1);
      check("t5_perfect", result_perfect, 0);
      check("t5_ready_low", pixel_ready, 0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("t5_valid_clr", result_valid, 0);
      check("t5_ready", pixel_ready, 1);

      // 6: reset mid LOAD_SRCH, then mid RUN
      send_frame(0, 600, -1);
      do_reset();
      check("t6a_ready", pixel_ready, 0);
      check("t6a_busy", busy, 0);
      tick();
      check("t6a_ready_back", pixel_ready, 1);
      send_frame(600, 680, 1279);
      check("t6a_partial_err", frame_error, 1);
      check("t6a_no_start", start_signal, 0);
      send_frame(0, 1280, 1279);
      check("t6b_start", start_signal, 1);
      do_reset();
      check("t6b_start_clr", start_signal, 0);
      check("t6b_valid", result_valid, 0);
      check("t6b_ready", pixel_ready, 0);
      tick();
      send_frame(0, 1024, 1023);
      check("t6b_short_err", frame_error, 1);
      check("t6b_no_start", start_signal, 0);
      send_frame(0, 1280, 1279);
      check("t6b_restart", start_signal, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
